// File: rtl/dtree_pkg.sv
// Shared types and node-word layout helpers for the sequential decision-tree classifier.
// Node word, MSB to LSB: leaf | fidx | shift | thr | left | right.
package dtree_pkg;

   typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

   function automatic int unsigned node_w(int unsigned n_feat, int unsigned feat_w,
                                          int unsigned n_nodes);
      return 1 + $clog2(n_feat) + $clog2(feat_w) + feat_w + 2 * $clog2(n_nodes);
   endfunction

   function automatic int unsigned off_right();
      return 0;
   endfunction

   function automatic int unsigned off_left(int unsigned n_nodes);
      return $clog2(n_nodes);
   endfunction

   function automatic int unsigned off_thr(int unsigned n_nodes);
      return 2 * $clog2(n_nodes);
   endfunction

   function automatic int unsigned off_shift(int unsigned feat_w, int unsigned n_nodes);
      return off_thr(n_nodes) + feat_w;
   endfunction

   function automatic int unsigned off_fidx(int unsigned feat_w, int unsigned n_nodes);
      return off_shift(feat_w, n_nodes) + $clog2(feat_w);
   endfunction

   function automatic int unsigned off_leaf(int unsigned n_feat, int unsigned feat_w,
                                            int unsigned n_nodes);
      return off_fidx(feat_w, n_nodes) + $clog2(n_feat);
   endfunction

endpackage

// File: rtl/dtree_node_eval.sv
// Combinational evaluation of one tree node against the latched feature vector.
module dtree_node_eval
   import dtree_pkg::*;
#(
   parameter int unsigned N_FEAT  = 6,
   parameter int unsigned FEAT_W  = 8,
   parameter int unsigned N_NODES = 32,
   parameter int unsigned CLASS_W = 2
) (
   input  logic [node_w(N_FEAT, FEAT_W, N_NODES)-1:0] node,
   input  logic [N_FEAT*FEAT_W-1:0]                   feat,
   output logic                                       is_leaf,
   output logic [$clog2(N_NODES)-1:0]                 next_node,
   output logic [CLASS_W-1:0]                         cls,
   output logic                                       bad_idx
);

   localparam int unsigned NODE_AW = $clog2(N_NODES);
   localparam int unsigned FIDX_W  = $clog2(N_FEAT);
   localparam int unsigned SH_W    = $clog2(FEAT_W);

   logic [FIDX_W-1:0]  fidx;
   logic [SH_W-1:0]    shift;
   logic [FEAT_W-1:0]  thr;
   logic [NODE_AW-1:0] left;
   logic [NODE_AW-1:0] right;
   logic [FEAT_W-1:0]  sel;

   assign is_leaf = node[off_leaf(N_FEAT, FEAT_W, N_NODES)];
   assign fidx    = node[off_fidx(FEAT_W, N_NODES) +: FIDX_W];
   assign shift   = node[off_shift(FEAT_W, N_NODES) +: SH_W];
   assign thr     = node[off_thr(N_NODES) +: FEAT_W];
   assign left    = node[off_left(N_NODES) +: NODE_AW];
   assign right   = node[off_right() +: NODE_AW];
   assign cls     = thr[CLASS_W-1:0];

   always_comb begin
      sel = '0;
      for (int i = 0; i < int'(N_FEAT); i++) begin
         if (fidx == FIDX_W'(i)) sel = feat[i*FEAT_W +: FEAT_W];
      end
   end

   assign bad_idx   = !is_leaf && (32'(fidx) >= 32'(N_FEAT));
   assign next_node = ((sel >> shift) <= thr) ? left : right;

endmodule

// File: rtl/seq_dtree_classifier.sv
// Table-driven decision-tree classifier: one node evaluated per clock from a runtime-loaded
// node table, with valid/ready handshakes on the feature input and the result output.
module seq_dtree_classifier
   import dtree_pkg::*;
#(
   parameter int unsigned N_FEAT    = 6,
   parameter int unsigned FEAT_W    = 8,
   parameter int unsigned N_NODES   = 32,
   parameter int unsigned CLASS_W   = 2,
   parameter int unsigned MAX_DEPTH = 15
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   input  logic [N_FEAT*FEAT_W-1:0]                   in_feat,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [CLASS_W-1:0]                         out_class,
   output logic [$clog2(MAX_DEPTH+1)-1:0]             out_depth,
   output logic                                       out_err,
   input  logic                                       cfg_we,
   input  logic [$clog2(N_NODES)-1:0]                 cfg_addr,
   input  logic [node_w(N_FEAT, FEAT_W, N_NODES)-1:0] cfg_data
);

   localparam int unsigned NODE_AW = $clog2(N_NODES);
   localparam int unsigned DEP_W   = $clog2(MAX_DEPTH+1);
   localparam int unsigned NODE_W  = node_w(N_FEAT, FEAT_W, N_NODES);

   // Node table is deliberately outside the reset domain so it survives rst_n.
   logic [NODE_W-1:0] table_q [N_NODES];

   state_e                  state_q;
   logic [N_FEAT*FEAT_W-1:0] feat_q;
   logic [NODE_AW-1:0]      node_q;
   logic [DEP_W-1:0]        depth_q;
   logic [DEP_W-1:0]        depth_d;
   logic [NODE_W-1:0]       cur_node;
   logic                    is_leaf;
   logic                    bad_idx;
   logic [NODE_AW-1:0]      next_node;
   logic [CLASS_W-1:0]      leaf_cls;

   assign cur_node = table_q[node_q];
   assign depth_d  = depth_q + DEP_W'(1);
   assign in_ready = (state_q == StIdle);

   dtree_node_eval #(
      .N_FEAT  (N_FEAT),
      .FEAT_W  (FEAT_W),
      .N_NODES (N_NODES),
      .CLASS_W (CLASS_W)
   ) u_eval (
      .node      (cur_node),
      .feat      (feat_q),
      .is_leaf   (is_leaf),
      .next_node (next_node),
      .cls       (leaf_cls),
      .bad_idx   (bad_idx)
   );

   always_ff @(posedge clk) begin
      if (cfg_we && state_q == StIdle) table_q[cfg_addr] <= cfg_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         feat_q    <= '0;
         node_q    <= '0;
         depth_q   <= '0;
         out_valid <= 1'b0;
         out_class <= '0;
         out_depth <= '0;
         out_err   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  feat_q  <= in_feat;
                  node_q  <= '0;
                  depth_q <= '0;
                  state_q <= StWalk;
               end
            end
            StWalk: begin
               // Leaf wins over the step limit, so a leaf at exactly MAX_DEPTH is a clean result.
               if (is_leaf || bad_idx || depth_d == DEP_W'(MAX_DEPTH)) begin
                  out_class <= is_leaf ? leaf_cls : '0;
                  out_err   <= !is_leaf;
                  out_depth <= depth_d;
                  out_valid <= 1'b1;
                  state_q   <= StDone;
               end else begin
                  node_q  <= next_node;
                  depth_q <= depth_d;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_dtree_classifier.sv
// Self-checking bench for seq_dtree_classifier: table vectors plus scoreboarded corner sequences.
module tb_seq_dtree_classifier;

   localparam int N_FEAT = 6;
   localparam int FEAT_W = 8;
   localparam int NODE_W = 25;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic                       in_valid;
   logic                       in_ready;
   logic [N_FEAT*FEAT_W-1:0]   in_feat;
   logic                       out_valid;
   logic                       out_ready;
   logic [1:0]                 out_class;
   logic [3:0]                 out_depth;
   logic                       out_err;
   logic                       cfg_we;
   logic [4:0]                 cfg_addr;
   logic [NODE_W-1:0]          cfg_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] cls;
      logic [3:0] depth;
      logic       err;
      int         lat;
   } exp_t;

   typedef struct {
      int x5;
      int cls;
   } vec_t;

   exp_t exp_q[$];

   seq_dtree_classifier dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_feat   (in_feat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_class (out_class),
      .out_depth (out_depth),
      .out_err   (out_err),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic logic [NODE_W-1:0] mk(bit leaf, int fidx, int sh, int thr, int l, int r);
      return {leaf, 3'(fidx), 3'(sh), 8'(thr), 5'(l), 5'(r)};
   endfunction

   function automatic logic [N_FEAT*FEAT_W-1:0] vec(int x5);
      logic [N_FEAT*FEAT_W-1:0] v;
      v = 48'({$urandom, $urandom});
      v[47:40] = 8'(x5);
      return v;
   endfunction

   function automatic exp_t ex(int cls, int depth, bit err, int lat);
      exp_t e;
      e.cls   = 2'(cls);
      e.depth = 4'(depth);
      e.err   = err;
      e.lat   = lat;
      return e;
   endfunction

   task automatic wr(int a, logic [NODE_W-1:0] d);
      cfg_we   = 1'b1;
      cfg_addr = 5'(a);
      cfg_data = d;
      step();
      cfg_we   = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 1);
   endtask

   task automatic send(logic [N_FEAT*FEAT_W-1:0] f, exp_t e);
      wait_idle();
      in_valid = 1'b1;
      in_feat  = f;
      step();
      in_valid = 1'b0;
      exp_q.push_back(e);
   endtask

   // Called right after the accept edge; counts cycles until out_valid.
   task automatic get_result(string name);
      int   lat = 0;
      exp_t e;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
      e = exp_q.pop_front();
      if (!out_valid) begin
         chk({name, "_timeout"}, 32'(out_valid), 1);
         return;
      end
      chk({name, "_class"}, 32'(out_class), 32'(e.cls));
      chk({name, "_depth"}, 32'(out_depth), 32'(e.depth));
      chk({name, "_err"}, 32'(out_err), 32'(e.err));
      chk({name, "_latency"}, 32'(lat), 32'(e.lat));
   endtask

   task automatic load_two();
      wait_idle();
      wr(0, mk(0, 5, 2, 3, 1, 2));
      wr(1, mk(1, 0, 0, 1, 0, 0));
      wr(2, mk(1, 0, 0, 3, 0, 0));
   endtask

   task automatic run_two(string tag);
      vec_t tbl[6];
      tbl = '{'{12, 1}, '{16, 3}, '{15, 1}, '{0, 1}, '{255, 3}, '{13, 1}};
      for (int i = 0; i < 6; i++) begin
         send(vec(tbl[i].x5), ex(tbl[i].cls, 2, 1'b0, 2));
         get_result($sformatf("%s_x5_%0d", tag, tbl[i].x5));
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_feat   = '0;
      out_ready = 1'b1;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_data  = '0;
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_class", 32'(out_class), 0);
      chk("rst_out_depth", 32'(out_depth), 0);
      chk("rst_out_err", 32'(out_err), 0);

      wr(0, mk(1, 0, 0, 2, 0, 0));
      send(vec($urandom_range(0, 255)), ex(2, 1, 1'b0, 1));
      get_result("single_leaf");

      load_two();
      run_two("two_level");

      // Linear chain: leaf at exactly the step limit, then one node too deep, then a self-loop.
      wait_idle();
      for (int i = 0; i < 14; i++)
         wr(i, mk(0, $urandom_range(0, 5), $urandom_range(0, 7), $urandom, i + 1, i + 1));
      wr(14, mk(1, 0, 0, 3, 0, 0));
      send(vec(0), ex(3, 15, 1'b0, 15));
      get_result("chain_leaf15");
      wait_idle();
      wr(14, mk(0, 0, 0, 0, 15, 15));
      wr(15, mk(1, 0, 0, 1, 0, 0));
      send(vec(0), ex(0, 15, 1'b1, 15));
      get_result("chain_limit");
      wait_idle();
      wr(0, mk(0, 0, 0, 0, 0, 0));
      send(vec(7), ex(0, 15, 1'b1, 15));
      get_result("self_loop");

      load_two();
      out_ready = 1'b0;
      send(vec(12), ex(1, 2, 1'b0, 2));
      get_result("bp_first");
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_out_valid", 32'(out_valid), 1);
         chk("bp_out_class", 32'(out_class), 1);
         chk("bp_out_depth", 32'(out_depth), 2);
         chk("bp_in_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      step();
      chk("bp_release_idle", 32'(in_ready), 1);
      chk("bp_release_valid", 32'(out_valid), 0);
      in_valid = 1'b1;
      in_feat  = vec(16);
      step();
      in_valid = 1'b0;
      chk("bp_next_accepted", 32'(in_ready), 0);
      exp_q.push_back(ex(3, 2, 1'b0, 2));
      get_result("bp_second");

      // Writes held through WALK and DONE must be dropped.
      wait_idle();
      send(vec(12), ex(1, 2, 1'b0, 2));
      out_ready = 1'b0;
      cfg_we    = 1'b1;
      cfg_addr  = 5'd1;
      cfg_data  = mk(1, 0, 0, 2, 0, 0);
      get_result("cfg_in_walk");
      step();
      step();
      cfg_we    = 1'b0;
      out_ready = 1'b1;
      send(vec(12), ex(1, 2, 1'b0, 2));
      get_result("cfg_table_kept");

      wait_idle();
      chk("same_cycle_idle", 32'(in_ready), 1);
      cfg_we   = 1'b1;
      cfg_addr = 5'd0;
      cfg_data = mk(1, 0, 0, 3, 0, 0);
      in_valid = 1'b1;
      in_feat  = vec(99);
      step();
      cfg_we   = 1'b0;
      in_valid = 1'b0;
      exp_q.push_back(ex(3, 1, 1'b0, 1));
      get_result("write_and_accept");

      wait_idle();
      wr(0, mk(0, 7, 0, 0, 1, 2));
      send(vec(0), ex(0, 1, 1'b1, 1));
      get_result("bad_fidx7");
      wait_idle();
      wr(0, mk(0, 6, 0, 0, 1, 2));
      send(vec(0), ex(0, 1, 1'b1, 1));
      get_result("bad_fidx6");

      load_two();
      send(vec(16), ex(3, 2, 1'b0, 2));
      get_result("pre_reset");
      send(vec(12), ex(1, 2, 1'b0, 2));
      void'(exp_q.pop_back());
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_out_class", 32'(out_class), 0);
      chk("mid_rst_out_depth", 32'(out_depth), 0);
      chk("mid_rst_out_err", 32'(out_err), 0);
      step();
      chk("mid_rst_in_ready", 32'(in_ready), 1);
      chk("mid_rst_no_result", 32'(out_valid), 0);
      run_two("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
